ex_mul_unit: RTL
================

# ex_mul_unit

Iterative shift-add multiplier in the execute stage. It consumes the operands and control fields produced by the ID/EX pipeline register. When a multiply is presented, it latches the operands and raises a stall toward the front end. It then computes the low 32 bits of the product over several cycles and emits a one-cycle result beat with destination register and write-enable for the EX/MEM path.

## Interface
- XLEN, 32, operand and result width
- CNT_W, 5, iteration counter width; equals log2(XLEN)
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- in_data_register_rs1  in  XLEN  multiplicand, from ID/EX
- in_data_register_rs2  in  XLEN  multiplier, from ID/EX
- in_reg_rd  in  5  destination register, from ID/EX
- in_alu_operation_type  in  4  request when equal to ALU_OP_MUL
- in_write_register  in  1  register write-enable of the instruction
- in_flush  in  1  branch/jump kill; blocks or aborts the operation
- out_stall  out  1  holds IF/ID/PC; drives the ID/EX in_stall
- out_valid  out  1  one-cycle result beat
- out_result  out  XLEN  product[XLEN-1:0]; meaningful only while out_valid is high
- out_reg_rd  out  5  latched destination register
- out_write_register  out  1  latched write-enable, gated by out_valid
- out_busy  out  1  state is not IDLE

## Operation
- States:
  - IDLE: no operation in progress.
  - BUSY: one iteration per cycle.
  - DONE: result presented for one cycle.
- Request: mul_req = (in_alu_operation_type == ALU_OP_MUL) && !in_flush.
- IDLE with mul_req: on the next edge, latch the operands and control fields.
  - mcand <= rs1, mplier <= rs2, acc <= 0, cnt <= 0.
  - State moves to BUSY.
- BUSY, each cycle:
  - If mplier[0] is set: acc <= acc + mcand, truncated to XLEN bits.
  - mcand <= mcand << 1.
  - mplier <= mplier >> 1.
  - cnt <= cnt + 1.
- BUSY exits to DONE on the edge where cnt == XLEN-1 is processed, giving XLEN iterations.
- DONE: out_valid = 1 and out_result = acc. On the next edge the state returns to IDLE.
- Requests are accepted only in IDLE. An ALU_OP_MUL seen in BUSY or DONE is ignored; stall ordering prevents one from arriving there.
- out_stall = (IDLE && mul_req) || BUSY. It is deasserted in DONE, so the next instruction enters ID/EX while the unit is in DONE and reaches the unit in IDLE.
- in_flush in BUSY or DONE: next state is IDLE and out_valid is suppressed in that cycle. The aborted result is never emitted.
- Arithmetic is unsigned modulo 2^XLEN; the low product bits are identical for signed operands. No overflow flag is produced.
- Reset is asserted, including mid-operation: the unit goes to IDLE immediately. All outputs are 0 and all internal registers are 0.

## Timing
- Reset values: out_stall=0, out_valid=0, out_result=0, out_reg_rd=0, out_write_register=0, out_busy=0.
- Accept edge E0. BUSY occupies the cycles after E0 through E32, and out_valid is high in the cycle after E32.
- Latency is therefore XLEN+1 cycles from the accept edge to the result.
- out_stall is combinational in the request cycle, so ID/EX bubbles on E0. It remains registered-state-driven for the rest of the operation.
- out_valid lasts exactly one cycle. It is never asserted for two consecutive cycles.

## Configuration
- MUL_EARLY_EXIT_EN defined:
  - BUSY also exits to DONE on the edge where the shifted mplier becomes 0, or immediately when mplier is 0 at entry to BUSY.
  - Latency becomes (index of the highest set bit of rs2) + 2 cycles, with a minimum of 2 cycles for rs2 == 0.
- Not defined: latency is fixed at XLEN+1 and the zero test is not synthesized.
- The result is identical in both builds.

## Structure
- Shared core definitions package: ALU_OP_MUL = 4'b1010, XLEN, and state encodings ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2.
- One sub-module, mul_datapath, holds the acc/mcand/mplier/cnt registers and the adder. It is controlled by load, step and clear strobes from the FSM in ex_mul_unit.

## Test plan
- rs1=7, rs2=6, rd=5, wr=1 → out_stall high from the request cycle. out_valid arrives 33 cycles after accept with result 42, rd=5, wr=1.
- rs1=0xFFFFFFFF, rs2=2 → result 0xFFFFFFFE. rs1=0x80000000, rs2=2 → result 0x00000000, confirming truncation.
- MUL_EARLY_EXIT_EN, rs1=6, rs2=7 → out_valid 4 cycles after accept with result 42. With rs2=0 → out_valid 2 cycles after accept with result 0.
- in_flush pulsed in BUSY cycle 10 → unit returns to IDLE. No out_valid follows, and out_stall drops the next cycle.
- reset driven low during BUSY cycle 20 → all outputs are 0 immediately. After release, a new 3×3 request yields 9.
- Back-to-back: MUL 3×4 then MUL 5×5 → two single-cycle out_valid beats, 12 then 25, with no request lost or duplicated.

Source files
------------

// File: rtl/ex_mul_unit_pkg.sv
// Shared core definitions for the execute-stage multiplier: ALU opcode, widths and FSM state encodings.
package ex_mul_unit_pkg;
  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [3:0] ALU_OP_MUL = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/ex_mul_unit_mul_datapath.sv
// Shift-add multiplier datapath: acc/mcand/mplier/cnt registers and adder, driven by load/step/clear strobes.
// MUL_EARLY_EXIT_EN adds a zero test on the remaining multiplier bits to finish early.
import ex_mul_unit_pkg::*;

module mul_datapath #(
  parameter int XLEN  = ex_mul_unit_pkg::XLEN,
  parameter int CNT_W = ex_mul_unit_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            clear,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] acc,
  output logic            finish
);
  logic [XLEN-1:0]  mcand;
  logic [XLEN-1:0]  mplier;
  logic [CNT_W-1:0] cnt;
  logic             last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (clear) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= op_a;
      mplier <= op_b;
      cnt    <= '0;
    end else if (step) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CNT_W'(XLEN - 1));

  // finish is sampled on the edge that performs the current iteration
`ifdef MUL_EARLY_EXIT_EN
  assign finish = last || (mplier[XLEN-1:1] == '0);
`else
  assign finish = last;
`endif
endmodule

// File: rtl/ex_mul_unit.sv
// Execute-stage iterative multiplier: stalls the front end, runs XLEN shift-add steps, emits a one-cycle result beat.
// Optional MUL_EARLY_EXIT_EN (in mul_datapath) ends the iteration once the remaining multiplier bits are zero.
import ex_mul_unit_pkg::*;

module ex_mul_unit #(
  parameter int XLEN  = ex_mul_unit_pkg::XLEN,
  parameter int CNT_W = ex_mul_unit_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] in_data_register_rs1,
  input  logic [XLEN-1:0] in_data_register_rs2,
  input  logic [4:0]      in_reg_rd,
  input  logic [3:0]      in_alu_operation_type,
  input  logic            in_write_register,
  input  logic            in_flush,
  output logic            out_stall,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_reg_rd,
  output logic            out_write_register,
  output logic            out_busy
);
  state_t          state;
  logic [4:0]      rd_q;
  logic            wr_q;
  logic            mul_req;
  logic            load;
  logic            step;
  logic            clear;
  logic            finish;
  logic [XLEN-1:0] acc;

  assign mul_req = (in_alu_operation_type == ALU_OP_MUL) && !in_flush;

  always_comb begin
    load  = (state == ST_IDLE) && mul_req;
    step  = (state == ST_BUSY) && !in_flush;
    clear = (state != ST_IDLE) && (in_flush || (state == ST_DONE));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      rd_q  <= '0;
      wr_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (mul_req) begin
          state <= ST_BUSY;
          rd_q  <= in_reg_rd;
          wr_q  <= in_write_register;
        end
        ST_BUSY: begin
          if (in_flush)    state <= ST_IDLE;
          else if (finish) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  mul_datapath #(.XLEN(XLEN), .CNT_W(CNT_W)) u_datapath (
    .clk    (clk),
    .rst_n  (reset),
    .load   (load),
    .step   (step),
    .clear  (clear),
    .op_a   (in_data_register_rs1),
    .op_b   (in_data_register_rs2),
    .acc    (acc),
    .finish (finish)
  );

  // Stall covers the request cycle combinationally so ID/EX bubbles on the accept edge
  assign out_stall          = reset && (((state == ST_IDLE) && mul_req) || (state == ST_BUSY));
  assign out_valid          = (state == ST_DONE) && !in_flush;
  assign out_result         = out_valid ? acc : '0;
  assign out_reg_rd         = rd_q;
  assign out_write_register = wr_q && out_valid;
  assign out_busy           = (state != ST_IDLE);
endmodule
